// File: rtl/dac_tx_pkg.sv
// Shared constants, state encoding and frame packing for the dac_tx serial DAC transmitter.
package dac_tx_pkg;

  localparam int DAC_BITS   = 12;
  localparam int FRAME_BITS = 16;
  localparam int PAD_BITS   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TX   = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Control bits in front of the DAC word are all zero (normal operation mode).
  function automatic logic [FRAME_BITS-1:0] make_frame(input logic [DAC_BITS-1:0] w);
    return {{PAD_BITS{1'b0}}, w};
  endfunction

endpackage

// File: rtl/dac_tx_if.sv
// Bundle between the filter chain, the dac_tx transmitter and the DAC serial pins.
interface dac_tx_if #(
  parameter int cant_bits = 25
);
  logic                 dato_listo;
  logic [cant_bits-1:0] y;
  logic                 sclk;
  logic                 sync_n;
  logic                 sdata;
  logic                 ocupado;
  logic                 fin;
  logic                 desborde;

  modport master (
    output dato_listo, y,
    input  sclk, sync_n, sdata, ocupado, fin, desborde
  );

  modport slave (
    input  dato_listo, y,
    output sclk, sync_n, sdata, ocupado, fin, desborde
  );
endinterface

// File: rtl/dac_tx_conv_dac.sv
// Combinational rescale of the filter output to a 12-bit offset-binary DAC word.
// Optional saturation instead of wrap-around is enabled with DAC_TX_SAT_EN.
module conv_dac
  import dac_tx_pkg::*;
#(
  parameter int cant_bits = 25,
  parameter int esc       = 10
) (
  input  logic signed [cant_bits-1:0] y,
  output logic        [DAC_BITS-1:0]  w
);

  logic signed [cant_bits-1:0] s;
  logic        [DAC_BITS-1:0]  d;

  assign s = y >>> esc;

`ifdef DAC_TX_SAT_EN
  localparam logic signed [cant_bits-1:0] S_MAX = cant_bits'(2047);
  localparam logic signed [cant_bits-1:0] S_MIN = -(cant_bits'(2048));

  always_comb begin
    d = DAC_BITS'(s);
    if (s > S_MAX) begin
      d = 12'h7FF;
    end else if (s < S_MIN) begin
      d = 12'h800;
    end
  end
`else
  assign d = DAC_BITS'(s);
`endif

  // Flipping the sign bit turns two's complement into offset binary.
  assign w = {~d[DAC_BITS-1], d[DAC_BITS-2:0]};

endmodule

// File: rtl/dac_tx.sv
// Serial DAC transmitter: captures filter samples and shifts 16-bit frames MSB-first to the DAC.
// Build option DAC_TX_SAT_EN (in conv_dac) saturates instead of wrapping; timing is unaffected.
module dac_tx
  import dac_tx_pkg::*;
#(
  parameter int cant_bits = 25,
  parameter int esc       = 10,
  parameter int div       = 2
) (
  input  logic     clk,
  input  logic     rst,
  dac_tx_if.slave  bus
);

  localparam int              CNT_W   = (div > 1) ? $clog2(div) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(div - 1);

  logic [DAC_BITS-1:0] conv_w;

  conv_dac #(.cant_bits(cant_bits), .esc(esc)) u_conv (
    .y (bus.y),
    .w (conv_w)
  );

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      div_cnt_q, div_cnt_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [DAC_BITS-1:0]   pend_q, pend_d;
  logic                  pend_valid_q, pend_valid_d;
  logic                  sclk_q, sclk_d;
  logic                  sync_n_q, sync_n_d;
  logic                  sdata_q, sdata_d;
  logic                  ocupado_q, ocupado_d;
  logic                  fin_q, fin_d;
  logic                  desborde_q, desborde_d;
  logic                  load_en;
  logic [DAC_BITS-1:0]   load_w;

  always_comb begin
    state_d      = state_q;
    div_cnt_d    = div_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    sclk_d       = sclk_q;
    sync_n_d     = sync_n_q;
    sdata_d      = sdata_q;
    ocupado_d    = ocupado_q;
    fin_d        = 1'b0;
    desborde_d   = desborde_q;
    load_en      = 1'b0;
    load_w       = conv_w;

    // Any strobe while busy lands in the pending slot, even on the FIN exit cycle.
    if (bus.dato_listo && (state_q != IDLE)) begin
      pend_d       = conv_w;
      pend_valid_d = 1'b1;
      if (pend_valid_q) begin
        desborde_d = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (bus.dato_listo) begin
          load_en = 1'b1;
        end
      end
      TX: begin
        if (div_cnt_q != CNT_MAX) begin
          div_cnt_d = div_cnt_q + CNT_W'(1);
        end else begin
          div_cnt_d = '0;
          if (sclk_q) begin
            sclk_d = 1'b0;
          end else if (bit_cnt_q == 4'd0) begin
            state_d  = FIN;
            sclk_d   = 1'b1;
            sync_n_d = 1'b1;
            sdata_d  = 1'b0;
          end else begin
            sclk_d    = 1'b1;
            shift_d   = {shift_q[FRAME_BITS-2:0], 1'b0};
            sdata_d   = shift_q[FRAME_BITS-2];
            bit_cnt_d = bit_cnt_q - 4'd1;
          end
        end
      end
      FIN: begin
        // After div quiet cycles, fin occupies one extra cycle and the exit happens there.
        if (fin_q) begin
          div_cnt_d = '0;
          if (pend_valid_d) begin
            load_en      = 1'b1;
            load_w       = pend_d;
            pend_valid_d = 1'b0;
          end else begin
            state_d   = IDLE;
            ocupado_d = 1'b0;
          end
        end else if (div_cnt_q == CNT_MAX) begin
          fin_d = 1'b1;
        end else begin
          div_cnt_d = div_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (load_en) begin
      state_d   = TX;
      shift_d   = make_frame(load_w);
      sdata_d   = shift_d[FRAME_BITS-1];
      div_cnt_d = '0;
      bit_cnt_d = 4'(FRAME_BITS - 1);
      sclk_d    = 1'b1;
      sync_n_d  = 1'b0;
      ocupado_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      div_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      sclk_q       <= 1'b1;
      sync_n_q     <= 1'b1;
      sdata_q      <= 1'b0;
      ocupado_q    <= 1'b0;
      fin_q        <= 1'b0;
      desborde_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_cnt_q    <= div_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      sclk_q       <= sclk_d;
      sync_n_q     <= sync_n_d;
      sdata_q      <= sdata_d;
      ocupado_q    <= ocupado_d;
      fin_q        <= fin_d;
      desborde_q   <= desborde_d;
    end
  end

  assign bus.sclk     = sclk_q;
  assign bus.sync_n   = sync_n_q;
  assign bus.sdata    = sdata_q;
  assign bus.ocupado  = ocupado_q;
  assign bus.fin      = fin_q;
  assign bus.desborde = desborde_q;

endmodule

// File: tb/tb_dac_tx.sv
// Self-checking bench for dac_tx: scoreboard of expected frames checked by a serial-line monitor.
// Expected words honour DAC_TX_SAT_EN the same way the design build does.
module tb_dac_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] exp_q[$];

  dac_tx_if #(.cant_bits(25)) bus ();

  dac_tx #(.cant_bits(25), .esc(10), .div(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference conversion: floor-scale, optionally clamp, then bias into offset binary.
  function automatic logic [15:0] model(input logic [24:0] v);
    int yi;
    int s;
    int w;
    yi = int'($signed(v));
    s  = yi >>> 10;
`ifdef DAC_TX_SAT_EN
    if (s > 2047)  s = 2047;
    if (s < -2048) s = -2048;
`endif
    w = (s + 2048) & 32'h0000_0FFF;
    return {4'b0000, w[11:0]};
  endfunction

  // Monitor: capture sdata on each sclk fall inside a frame, compare when sync_n rises.
  logic [15:0] mon_word   = '0;
  int          mon_bits   = 0;
  logic        mon_active = 1'b0;
  logic        mon_prev   = 1'b1;
  logic [15:0] mon_exp;

  always @(negedge clk) begin
    if (rst) begin
      mon_bits   = 0;
      mon_active = 1'b0;
      mon_prev   = 1'b1;
    end else begin
      if (!bus.sync_n) begin
        mon_active = 1'b1;
        if (mon_prev && !bus.sclk) begin
          mon_word = {mon_word[14:0], bus.sdata};
          mon_bits++;
        end
      end else if (mon_active) begin
        mon_active = 1'b0;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("[TB] FAIL frame: unexpected frame %h (%0d bits), none required", mon_word, mon_bits);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_bits != 16 || mon_word !== mon_exp) begin
            n_err++;
            $display("[TB] FAIL frame: got %h with %0d bits, required %h with 16 bits", mon_word, mon_bits, mon_exp);
          end
        end
        mon_bits = 0;
      end
      mon_prev = bus.sclk;
    end
  end

  task automatic strobe(input logic [24:0] v);
    bus.y          = v;
    bus.dato_listo = 1'b1;
    @(negedge clk);
    bus.dato_listo = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((bus.ocupado || exp_q.size() != 0) && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (k >= 400) begin
      n_cmp++;
      n_err++;
      $display("[TB] FAIL wait_idle: timed out, ocupado=%b pending frames=%0d, required 0/0", bus.ocupado, exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.dato_listo = 1'b0;
    bus.y          = '0;
    rst            = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({bus.sclk, bus.sync_n, bus.sdata, bus.ocupado, bus.fin, bus.desborde} !== 6'b110000) begin
      n_err++;
      $display("[TB] FAIL reset_values: got sclk,sync_n,sdata,ocupado,fin,desborde=%b, required 110000",
               {bus.sclk, bus.sync_n, bus.sdata, bus.ocupado, bus.fin, bus.desborde});
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.sclk, bus.sync_n, bus.ocupado} !== 3'b110) begin
      n_err++;
      $display("[TB] FAIL idle_after_reset: got sclk,sync_n,ocupado=%b, required 110", {bus.sclk, bus.sync_n, bus.ocupado});
    end
  endtask

  task automatic test_single_frame();
    int   low_cnt = 0;
    int   falls = 0;
    int   first_fall = -1;
    int   fin_cyc = -1;
    int   fin_cnt = 0;
    logic prev_sclk = 1'b1;
    logic ocup67 = 1'b0;
    logic ocup68 = 1'b1;
    exp_q.push_back(16'h0801);
    strobe(25'h0000400);
    n_cmp++;
    if ({bus.sync_n, bus.ocupado, bus.sdata} !== 3'b010) begin
      n_err++;
      $display("[TB] FAIL first_cycle: got sync_n,ocupado,sdata=%b, required 010", {bus.sync_n, bus.ocupado, bus.sdata});
    end
    for (int c = 1; c <= 70; c++) begin
      if (!bus.sync_n) low_cnt++;
      if (prev_sclk && !bus.sclk) begin
        falls++;
        if (first_fall < 0) first_fall = c;
      end
      if (bus.fin) begin
        fin_cnt++;
        fin_cyc = c;
      end
      if (c == 67) ocup67 = bus.ocupado;
      if (c == 68) ocup68 = bus.ocupado;
      prev_sclk = bus.sclk;
      @(negedge clk);
    end
    n_cmp++;
    if (first_fall != 3) begin
      n_err++;
      $display("[TB] FAIL first_sclk_fall: got cycle %0d, required 3", first_fall);
    end
    n_cmp++;
    if (falls != 16) begin
      n_err++;
      $display("[TB] FAIL sclk_falls: got %0d, required 16", falls);
    end
    n_cmp++;
    if (low_cnt != 64) begin
      n_err++;
      $display("[TB] FAIL sync_n_low: got %0d cycles, required 64", low_cnt);
    end
    n_cmp++;
    if (fin_cnt != 1 || fin_cyc != 67) begin
      n_err++;
      $display("[TB] FAIL fin_pulse: got %0d pulses last at cycle %0d, required 1 at 67", fin_cnt, fin_cyc);
    end
    n_cmp++;
    if (ocup67 !== 1'b1 || ocup68 !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL ocupado_drop: got cycle67=%b cycle68=%b, required 1 0", ocup67, ocup68);
    end
    wait_idle();
  endtask

  task automatic test_conversions();
    logic [24:0] vals[3];
    vals[0] = 25'h1FFFC00;
    vals[1] = 25'h0100000;
    vals[2] = 25'h0000000;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(model(vals[i]));
      strobe(vals[i]);
      wait_idle();
    end
  endtask

  task automatic test_saturation();
    logic [24:0] vals[2];
    vals[0] = 25'h0200000;
    vals[1] = 25'h1E00000;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(model(vals[i]));
      strobe(vals[i]);
      wait_idle();
    end
  endtask

  task automatic test_back_to_back();
    int   gaps = 0;
    int   start2 = -1;
    logic prev_sync = 1'b0;
    logic ocup_end = 1'b1;
    logic desb = 1'b0;
    exp_q.push_back(model(25'h0000400));
    exp_q.push_back(model(25'h0100000));
    bus.y          = 25'h0000400;
    bus.dato_listo = 1'b1;
    for (int c = 1; c <= 136; c++) begin
      @(negedge clk);
      bus.dato_listo = (c == 10);
      if (c == 10) bus.y = 25'h0100000;
      if (c <= 134 && bus.ocupado !== 1'b1) gaps++;
      if (c == 135) ocup_end = bus.ocupado;
      if (c > 1 && prev_sync && !bus.sync_n && start2 < 0) start2 = c;
      if (bus.desborde) desb = 1'b1;
      prev_sync = bus.sync_n;
    end
    n_cmp++;
    if (gaps != 0 || ocup_end !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL b2b_ocupado: got %0d low cycles and end=%b, required 0 and 0", gaps, ocup_end);
    end
    n_cmp++;
    if (start2 != 68) begin
      n_err++;
      $display("[TB] FAIL b2b_period: second frame at cycle %0d, required 68", start2);
    end
    n_cmp++;
    if (desb !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL b2b_desborde: got %b, required 0", desb);
    end
    wait_idle();
  endtask

  task automatic test_overflow();
    logic d20 = 1'b1;
    logic d21 = 1'b0;
    exp_q.push_back(model(25'h0000400));
    exp_q.push_back(model(25'h1FFFC00));
    bus.y          = 25'h0000400;
    bus.dato_listo = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      bus.dato_listo = (c == 10 || c == 20);
      if (c == 10) bus.y = 25'h0100000;
      if (c == 20) bus.y = 25'h1FFFC00;
      if (c == 20) d20 = bus.desborde;
      if (c == 21) d21 = bus.desborde;
    end
    n_cmp++;
    if (d20 !== 1'b0 || d21 !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL desborde_set: got cycle20=%b cycle21=%b, required 0 1", d20, d21);
    end
    wait_idle();
    n_cmp++;
    if (bus.desborde !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL desborde_sticky: got %b, required 1", bus.desborde);
    end
  endtask

  task automatic test_reset_mid_frame();
    int stray = 0;
    strobe(25'h0000400);
    repeat (29) @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.sclk, bus.sync_n, bus.ocupado, bus.fin, bus.desborde} !== 5'b11000) begin
      n_err++;
      $display("[TB] FAIL reset_mid_frame: got sclk,sync_n,ocupado,fin,desborde=%b, required 11000",
               {bus.sclk, bus.sync_n, bus.ocupado, bus.fin, bus.desborde});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.fin || !bus.sync_n || bus.ocupado) stray++;
    end
    n_cmp++;
    if (stray != 0) begin
      n_err++;
      $display("[TB] FAIL reset_discard: got %0d active cycles after reset, required 0", stray);
    end
    exp_q.push_back(model(25'h0100000));
    strobe(25'h0100000);
    wait_idle();
  endtask

  initial begin
    bus.dato_listo = 1'b0;
    bus.y          = '0;
    test_reset();
    test_single_frame();
    test_conversions();
    test_saturation();
    test_back_to_back();
    test_overflow();
    test_reset_mid_frame();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
